// File: rtl/mmio_sensor_hub.sv
// mmio_sensor_hub
//   Memory-mapped I/O hub sitting between the processor data port and board I/O.
//   Raw sensor inputs are synchronised (2 flops) and debounced per channel.
//   The hub keeps sticky rise/fall flags, saturating per-channel rising-edge
//   counters, an interrupt-enable mask and an LED register. Hub register reads
//   are merged with RAM read data so the processor sees one address space.
//
// Ports
//   clock       in   1       system clock, all state on the rising edge
//   reset       in   1       synchronous active-low reset
//   sensor_in   in   NUM_CH  raw asynchronous sensor levels
//   addr        in   32      processor dmem word address
//   wEn         in   1       processor dmem write enable
//   dataIn      in   32      processor write data
//   RAMDataOut  in   32      RAM read data (1-cycle read latency)
//   dataOut     out  32      merged read data
//   irq         out  1       level interrupt, |(RISE & IRQ_EN)
//   LED         out  16      LED register contents
//
// Register map (word offsets from MMIO_BASE, 32-word region)
//   0 STATE  RO   debounced levels
//   1 RISE   W1C  sticky rising-edge flags
//   2 FALL   W1C  sticky falling-edge flags
//   3 IRQ_EN RW   interrupt enable per channel
//   4 LED    RW   low 16 bits drive LED
//   8+i CNT_i     rising-edge count of channel i; any write clears it
//
// Read timing: the bus has no valid/ready handshake. An address presented in
// cycle n is answered in cycle n+1, exactly like the RAM: sel_q remembers
// whether that address hit the hub and rdata_q holds the register value
// sampled before that edge's own updates.
module mmio_sensor_hub #(
  parameter int          NUM_CH          = 8,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] MMIO_BASE       = 32'h0000_0F00,
  parameter int          CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sensor_in,
  input  logic [31:0]       addr,
  input  logic              wEn,
  input  logic [31:0]       dataIn,
  input  logic [31:0]       RAMDataOut,
  output logic [31:0]       dataOut,
  output logic              irq,
  output logic [15:0]       LED
);

  localparam int              DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // 33-bit bounds so a base near the top of the address space cannot wrap.
  localparam logic [32:0]     BASE_EXT = {1'b0, MMIO_BASE};
  localparam logic [32:0]     LIMIT    = BASE_EXT + 33'd32;

  localparam logic [4:0] OFF_STATE  = 5'd0;
  localparam logic [4:0] OFF_RISE   = 5'd1;
  localparam logic [4:0] OFF_FALL   = 5'd2;
  localparam logic [4:0] OFF_IRQ_EN = 5'd3;
  localparam logic [4:0] OFF_LED    = 5'd4;
  localparam logic [4:0] OFF_CNT0   = 5'd8;

  logic [NUM_CH-1:0] sync_a;
  logic [NUM_CH-1:0] sync_b;
  logic [NUM_CH-1:0] stable;
  logic [DB_W-1:0]   db_cnt [NUM_CH];
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;

  logic [NUM_CH-1:0] rise_flags;
  logic [NUM_CH-1:0] fall_flags;
  logic [NUM_CH-1:0] irq_en;
  logic [15:0]       led_q;
  logic [CNT_W-1:0]  ev_cnt [NUM_CH];

  logic              hit;
  logic              wr;
  logic [4:0]        off;
  logic [NUM_CH-1:0] rise_clr;
  logic [NUM_CH-1:0] fall_clr;
  logic [NUM_CH-1:0] cnt_clr;
  logic [31:0]       rd_mux;
  logic              sel_q;
  logic [31:0]       rdata_q;

  // Upper write-data bits have no register behind them.
  logic              unused_data;
  assign unused_data = ^dataIn[31:16];

  // ---------------------------------------------------------------------------
  // Address decode. Only the low 5 bits of the difference matter, and those
  // depend only on the low 5 bits of the operands.
  // ---------------------------------------------------------------------------
  assign hit = ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT);
  assign off = addr[4:0] - MMIO_BASE[4:0];
  assign wr  = wEn && hit;

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------------
  // A pulse fires on the same edge that stable takes the new level.
  always_comb begin
    rise_pulse = '0;
    fall_pulse = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((sync_b[i] != stable[i]) && (db_cnt[i] == DB_LAST)) begin
        rise_pulse[i] = sync_b[i];
        fall_pulse[i] = ~sync_b[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_a <= sensor_in;
      sync_b <= sync_a;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_b[i] == stable[i]) begin
          // Level agrees with the accepted one: any partial count is a glitch.
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    cnt_clr  = '0;
    if (wr) begin
      case (off)
        OFF_RISE: rise_clr = dataIn[NUM_CH-1:0];
        OFF_FALL: fall_clr = dataIn[NUM_CH-1:0];
        default:  ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_clr[i] = (off == (OFF_CNT0 + 5'(i)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hub registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      rise_flags <= '0;
      fall_flags <= '0;
      irq_en     <= '0;
      led_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ev_cnt[i] <= '0;
      end
    end else begin
      // Set wins over a same-cycle W1C so no edge is ever lost.
      rise_flags <= (rise_flags & ~rise_clr) | rise_pulse;
      fall_flags <= (fall_flags & ~fall_clr) | fall_pulse;
      if (wr && (off == OFF_IRQ_EN)) begin
        irq_en <= dataIn[NUM_CH-1:0];
      end
      if (wr && (off == OFF_LED)) begin
        led_q <= dataIn[15:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise_pulse[i]) begin
          // A clear racing an edge keeps that edge: the count restarts at 1.
          if (cnt_clr[i]) begin
            ev_cnt[i] <= CNT_W'(1);
          end else if (ev_cnt[i] != CNT_MAX) begin
            ev_cnt[i] <= ev_cnt[i] + CNT_W'(1);
          end
        end else if (cnt_clr[i]) begin
          ev_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATE:  rd_mux[NUM_CH-1:0] = stable;
      OFF_RISE:   rd_mux[NUM_CH-1:0] = rise_flags;
      OFF_FALL:   rd_mux[NUM_CH-1:0] = fall_flags;
      OFF_IRQ_EN: rd_mux[NUM_CH-1:0] = irq_en;
      OFF_LED:    rd_mux[15:0]       = led_q;
      default:    ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (off == (OFF_CNT0 + 5'(i))) begin
        rd_mux[CNT_W-1:0] = ev_cnt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sel_q   <= hit;
      rdata_q <= rd_mux;
    end
  end

  assign dataOut = sel_q ? rdata_q : RAMDataOut;
  assign irq     = |(rise_flags & irq_en);
  assign LED     = led_q;

endmodule

// File: tb/tb_mmio_sensor_hub.sv
// Testbench for mmio_sensor_hub (NUM_CH=8, DEBOUNCE_CYCLES=16, CNT_W=4).
// Driver tasks push expected read data into exp_q; a monitor pops and compares
// on the cycle the read data is presented on dataOut.
module tb_mmio_sensor_hub;

  localparam int          NUM_CH = 8;
  localparam int          DEB    = 16;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0F00;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] sensor_in;
  logic [31:0]       addr;
  logic              wEn;
  logic [31:0]       dataIn;
  logic [31:0]       RAMDataOut = 32'h0;
  logic [31:0]       dataOut;
  logic              irq;
  logic [15:0]       LED;

  logic              rd_req = 1'b0;
  logic              rd_vld = 1'b0;
  logic [31:0]       exp_q[$];
  string             name_q[$];
  int                n_cmp = 0;
  int                n_err = 0;

  mmio_sensor_hub #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .MMIO_BASE(BASE), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .sensor_in(sensor_in), .addr(addr),
    .wEn(wEn), .dataIn(dataIn), .RAMDataOut(RAMDataOut),
    .dataOut(dataOut), .irq(irq), .LED(LED)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clock = ~clock;

  // RAM model with 1-cycle read latency; word 0x010 holds 0xDEADBEEF.
  always @(posedge clock) begin
    RAMDataOut <= (addr == 32'h0000_0010) ? 32'hDEAD_BEEF : {16'hC0DE, addr[15:0]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) rd_vld <= rd_req;

  always @(negedge clock) begin
    if (rd_vld) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL read_unexpected: got %h, expected queue empty", dataOut);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (dataOut !== e) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", nm, dataOut, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      addr = 32'h0; wEn = 1'b0; dataIn = 32'h0; rd_req = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    addr = BASE + 32'(off); wEn = 1'b1; dataIn = d; rd_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    addr = a; wEn = 1'b0; dataIn = 32'h0; rd_req = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clock);
  endtask

  // Holds channel ch high for 21 cycles then low for 21: one clean rise+fall.
  task automatic clean_pulse(input int ch);
    sensor_in[ch] = 1'b1;
    idle(21);
    sensor_in[ch] = 1'b0;
    idle(21);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; sensor_in = '0; addr = 32'h0; wEn = 1'b0; dataIn = 32'h0;
    repeat (3) @(negedge clock);
    check("reset_led", {16'h0, LED}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_dataout_ram", dataOut, 32'hC0DE_0000);
    reset = 1'b1;

    rd(BASE + 32'd4, 32'h0, "reset_led_reg");
    rd(BASE + 32'd0, 32'h0, "reset_state");
    rd(BASE + 32'd1, 32'h0, "reset_rise");
    rd(BASE + 32'd3, 32'h0, "reset_irq_en");

    // Debounce: STATE flips on edge 18 after the pin change.
    sensor_in[2] = 1'b1;
    idle(17);
    rd(BASE, 32'h0, "deb_state_edge18_old");
    rd(BASE, 32'h04, "deb_state_edge19");
    rd(BASE + 32'd1, 32'h04, "deb_rise");
    rd(BASE + 32'd10, 32'h1, "deb_cnt2");

    // Mux: RAM word then hub LED register on consecutive cycles, boundaries.
    wr(5'd4, 32'h0000_00A5);
    check("led_port", {16'h0, LED}, 32'h0000_00A5);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "mux_ram");
    rd(BASE + 32'd4, 32'h0000_00A5, "mux_led");
    rd(BASE + 32'd6, 32'h0, "mux_off6");
    rd(BASE + 32'd32, 32'hC0DE_0F20, "mux_above_region");
    rd(BASE - 32'd1, 32'hC0DE_0EFF, "mux_below_region");

    wr(5'd1, 32'h04);
    rd(BASE + 32'd1, 32'h0, "w1c_rise");

    // Glitch on ch0: 10 cycles high, no edge.
    sensor_in[0] = 1'b1;
    idle(10);
    sensor_in[0] = 1'b0;
    idle(20);
    rd(BASE, 32'h04, "glitch_state");
    rd(BASE + 32'd1, 32'h0, "glitch_rise");
    rd(BASE + 32'd8, 32'h0, "glitch_cnt0");

    // Clean pulse on ch0.
    sensor_in[0] = 1'b1;
    idle(19);
    rd(BASE + 32'd1, 32'h01, "clean_rise");
    rd(BASE + 32'd2, 32'h0, "clean_fall_before");
    sensor_in[0] = 1'b0;
    idle(20);
    rd(BASE + 32'd2, 32'h01, "clean_fall");
    rd(BASE + 32'd8, 32'h1, "clean_cnt0");
    wr(5'd1, 32'h01);
    wr(5'd2, 32'h01);

    // Drop ch2, clear its FALL, enable its interrupt.
    sensor_in[2] = 1'b0;
    idle(20);
    wr(5'd2, 32'h04);
    wr(5'd3, 32'h04);
    check("irq_idle", {31'h0, irq}, 32'h0);

    // W1C race: clear RISE bit2 on the very edge its rise pulse fires.
    sensor_in[2] = 1'b1;
    idle(17);
    wr(5'd1, 32'h04);
    check("race_irq_set", {31'h0, irq}, 32'h1);
    rd(BASE + 32'd1, 32'h04, "race_rise_kept");
    wr(5'd1, 32'h04);
    check("w1c_irq_drop", {31'h0, irq}, 32'h0);
    rd(BASE + 32'd1, 32'h0, "w1c_rise_cleared");
    rd(BASE + 32'd10, 32'h2, "race_cnt2");

    // Saturation on ch1 with a 4-bit counter.
    for (int k = 0; k < 20; k++) clean_pulse(1);
    rd(BASE + 32'd9, 32'hF, "sat_cnt1");
    wr(5'd9, 32'h0);
    rd(BASE + 32'd9, 32'h0, "clr_cnt1");
    clean_pulse(1);
    rd(BASE + 32'd9, 32'h1, "after_clr_cnt1");

    // Clear racing a rise pulse: the count restarts at 1.
    sensor_in[1] = 1'b1;
    idle(17);
    wr(5'd9, 32'hFFFF_FFFF);
    idle(1);
    rd(BASE + 32'd9, 32'h1, "race_clr_cnt1");
    rd(BASE + 32'd1, 32'h02, "rise_ch1_only");
    check("irq_masked", {31'h0, irq}, 32'h0);
    rd(BASE, 32'h06, "final_state");

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
